// File: rtl/floo_stub_pkg.sv
// Shared types for the NoC endpoint stub: ready-policy modes and the
// response code returned for every terminated packet.
package floo_stub_pkg;

  typedef enum logic [1:0] {
    SINK     = 2'd0,
    THROTTLE = 2'd1,
    BLOCK    = 2'd2,
    RESPOND  = 2'd3
  } stub_mode_e;

  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/floo_stub_endpoint.sv
// Terminating endpoint for a router Eject port: registered round-robin ready,
// per-channel flit counters, sticky error flag and DECERR response FIFO.
module floo_stub_endpoint
  import floo_stub_pkg::*;
#(
  parameter int unsigned NumChannels  = 3,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned IdWidth      = 8,
  parameter int unsigned IdOffset     = 0,
  parameter int unsigned CntWidth     = 16,
  parameter int unsigned RspFifoDepth = 4,
  parameter int unsigned StallWidth   = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic [1:0]                       mode_i,
  input  logic [StallWidth-1:0]            stall_cycles_i,
  input  logic [NumChannels-1:0]           in_valid_i,
  output logic [NumChannels-1:0]           in_ready_o,
  input  logic [NumChannels-1:0]           in_last_i,
  input  logic [NumChannels*DataWidth-1:0] in_data_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [IdWidth+1:0]               rsp_data_o,
  output logic [NumChannels*CntWidth-1:0]  flit_cnt_o,
  output logic [DataWidth-1:0]             last_data_o,
  output logic                             err_o
);

  localparam int unsigned PtrW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned AddrW = $clog2(RspFifoDepth);
  localparam int unsigned UsedW = AddrW + 1;
  localparam int unsigned RspW  = IdWidth + 2;

  logic [NumChannels-1:0]                ready_q, ready_d;
  logic [PtrW-1:0]                       ptr_q, ptr_d;
  logic [StallWidth-1:0]                 stall_q, stall_d;
  stub_mode_e                            mode_q, mode_d;
  logic [NumChannels-1:0][CntWidth-1:0]  cnt_q, cnt_d;
  logic [DataWidth-1:0]                  last_q, last_d;
  logic                                  err_q, err_d;
  logic [RspFifoDepth-1:0][RspW-1:0]     mem_q, mem_d;
  logic [AddrW-1:0]                      wr_q, wr_d, rd_q, rd_d;
  logic [UsedW-1:0]                      used_q, used_d;

  logic [NumChannels-1:0] accept, grant;
  logic                   any_acc, acc_last, push, pop, full_next, found;
  logic [PtrW-1:0]        acc_idx, rr_idx;
  logic [DataWidth-1:0]   acc_data;

  always_comb begin
    accept   = in_valid_i & ready_q;
    any_acc  = |accept;
    acc_idx  = '0;
    acc_data = '0;
    acc_last = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      if (accept[c]) begin
        acc_idx  = PtrW'(c);
        acc_data = in_data_i[c*DataWidth +: DataWidth];
        acc_last = in_last_i[c];
      end
    end

    // mode_q is the mode that produced this cycle's ready, so it decides pushes
    push = any_acc && acc_last && (mode_q == RESPOND) && !clear_i;
    pop  = (used_q != '0) && rsp_ready_i;

    mem_d = mem_q;
    if (push) mem_d[wr_q] = {acc_data[IdOffset +: IdWidth], DECERR};
    wr_d   = push ? wr_q + AddrW'(1) : wr_q;
    rd_d   = pop  ? rd_q + AddrW'(1) : rd_q;
    used_d = used_q;
    if (push && !pop)      used_d = used_q + UsedW'(1);
    else if (!push && pop) used_d = used_q - UsedW'(1);

    cnt_d = cnt_q;
    for (int c = 0; c < NumChannels; c++) begin
      if (accept[c] && (cnt_q[c] != '1)) cnt_d[c] = cnt_q[c] + CntWidth'(1);
    end
    err_d  = err_q | any_acc;
    last_d = any_acc ? acc_data : last_q;

    // clear wins over a same-cycle accept; the handshake itself still completes
    if (clear_i) begin
      cnt_d  = '0;
      err_d  = 1'b0;
      last_d = '0;
      wr_d   = '0;
      rd_d   = '0;
      used_d = '0;
    end
  end

  always_comb begin
    mode_d = stub_mode_e'(mode_i);

    ptr_d = ptr_q;
    if (any_acc) ptr_d = (acc_idx == PtrW'(NumChannels - 1)) ? '0 : acc_idx + PtrW'(1);

    stall_d = stall_q;
    if (any_acc && (mode_d == THROTTLE)) stall_d = stall_cycles_i;
    else if (stall_q != '0)               stall_d = stall_q - StallWidth'(1);

    full_next = (used_d == UsedW'(RspFifoDepth));

    // grant looks at current valids so the next-cycle ready lands on a requester
    grant  = '0;
    found  = 1'b0;
    rr_idx = '0;
    for (int k = 0; k < NumChannels; k++) begin
      rr_idx = PtrW'((int'(ptr_d) + k) % NumChannels);
      if (!found && in_valid_i[rr_idx]) begin
        grant[rr_idx] = 1'b1;
        found         = 1'b1;
      end
    end

    ready_d = '0;
    case (mode_d)
      SINK:     ready_d = grant;
      THROTTLE: if (stall_d == '0) ready_d = grant;
      RESPOND:  if (!full_next) ready_d = grant;
      default:  ready_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
      mode_q  <= SINK;
      cnt_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      used_q  <= '0;
    end else begin
      ready_q <= ready_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      used_q  <= used_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign rsp_valid_o = (used_q != '0);
  assign rsp_data_o  = mem_q[rd_q];
  assign flit_cnt_o  = cnt_q;
  assign last_data_o = last_q;
  assign err_o       = err_q;

endmodule
